// File: rtl/regbank_param.sv
// Parametrised 2-read/1-write register file with byte-lane writes, optional
// hardwired-zero entry 0, optional write-to-read bypass and a sequential clear engine.
module regbank_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                write,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   dr,
  input  logic [DATA_W-1:0]   wrData,
  input  logic [ADDR_W-1:0]   Sr1,
  input  logic [ADDR_W-1:0]   Sr2,
  output logic [DATA_W-1:0]   rdData1,
  output logic [DATA_W-1:0]   rdData2,
  output logic                busy,
  output logic                wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NLANE = DATA_W / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_wr_drop;
  logic                w_busy;
  logic                w_wr_req;
  logic                w_wr_acc;
  logic [DATA_W-1:0]   w_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:    if (!clr && r_cnt == '1) w_next = READY;
      READY:   if (clr) w_next = INIT;
      default: w_next = INIT;
    endcase
  end

  always_comb begin
    w_busy = (r_state == INIT);
  end

  // clr restarts the sweep from entry 0 whether idle or already clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (clr)     r_cnt <= '0;
    else if (w_busy)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_wr_req = write && (wr_be != '0);
  assign w_wr_acc = w_wr_req && !w_busy && !clr && !(ZERO_REG && dr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_drop <= 1'b0;
    else        r_wr_drop <= w_wr_req && (w_busy || clr);
  end

  always_comb begin
    w_merged = r_mem[dr];
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (wr_be[i]) w_merged[8*i +: 8] = wrData[8*i +: 8];
    end
  end

  // Storage is deliberately unreset; the clear engine zeroes it entry by entry.
  always_ff @(posedge clk) begin
    if (w_busy)        r_mem[r_cnt] <= '0;
    else if (w_wr_acc) r_mem[dr]    <= w_merged;
  end

  always_comb begin
    rdData1 = '0;
    if (!w_busy && !(ZERO_REG && Sr1 == '0))
      rdData1 = (BYPASS && w_wr_acc && Sr1 == dr) ? w_merged : r_mem[Sr1];
  end

  always_comb begin
    rdData2 = '0;
    if (!w_busy && !(ZERO_REG && Sr2 == '0))
      rdData2 = (BYPASS && w_wr_acc && Sr2 == dr) ? w_merged : r_mem[Sr2];
  end

  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regbank_param.sv
// Bench for regbank_param: a default instance (32 entries, zero reg, bypass) and an
// 8-entry instance without zero reg or bypass share stimulus, both checked against a model.
module tb_regbank_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [4:0]  dr = '0;
  logic [31:0] wrData = '0;
  logic [4:0]  Sr1 = '0;
  logic [4:0]  Sr2 = '0;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b, drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  regbank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .write(write), .wr_be(wr_be), .dr(dr),
    .wrData(wrData), .Sr1(Sr1), .Sr2(Sr2), .rdData1(rd1_a), .rdData2(rd2_a),
    .busy(busy_a), .wr_drop(drop_a)
  );

  regbank_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .write(write), .wr_be(wr_be), .dr(dr[2:0]),
    .wrData(wrData), .Sr1(Sr1[2:0]), .Sr2(Sr2[2:0]), .rdData1(rd1_b), .rdData2(rd2_b),
    .busy(busy_b), .wr_drop(drop_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Index 0 models u_dut, index 1 models u_alt. A clear is modelled as an
  // instantaneous wipe plus a count of remaining busy cycles.
  logic [31:0] m_mem [2][32];
  int          m_busy_left [2];
  logic        m_drop [2];

  function automatic int depth_of(int k);   return (k == 0) ? 32 : 8; endfunction
  function automatic bit zr_of(int k);      return (k == 0);          endfunction
  function automatic bit byp_of(int k);     return (k == 0);          endfunction
  function automatic int addr_of(int k, logic [4:0] a);
    return int'(a) % depth_of(k);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit accepted(int k);
    return rst_n && m_busy_left[k] == 0 && !clr && write && wr_be != 0 &&
           !(zr_of(k) && addr_of(k, dr) == 0);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] sr);
    int a = addr_of(k, sr);
    int w = addr_of(k, dr);
    if (m_busy_left[k] > 0) return 32'h0;
    if (zr_of(k) && a == 0) return 32'h0;
    if (byp_of(k) && accepted(k) && a == w) return merge(m_mem[k][w], wrData, wr_be);
    return m_mem[k][a];
  endfunction

  task automatic model_wipe(int k);
    for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
    m_busy_left[k] = depth_of(k);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_wipe(k);
      m_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit wreq = write && (wr_be != 0);
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int w = addr_of(k, dr);
      if (m_busy_left[k] > 0) begin
        m_drop[k] = wreq;
        if (clr) m_busy_left[k] = depth_of(k);
        else     m_busy_left[k] = m_busy_left[k] - 1;
      end else if (clr) begin
        m_drop[k] = wreq;
        model_wipe(k);
      end else begin
        m_drop[k] = 1'b0;
        if (wreq && !(zr_of(k) && w == 0)) m_mem[k][w] = merge(m_mem[k][w], wrData, wr_be);
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("main.busy", 32'(busy_a), 32'(m_busy_left[0] > 0));
    chk("main.drop", 32'(drop_a), 32'(m_drop[0]));
    chk("main.rd1",  rd1_a, exp_rd(0, Sr1));
    chk("main.rd2",  rd2_a, exp_rd(0, Sr2));
    chk("alt.busy",  32'(busy_b), 32'(m_busy_left[1] > 0));
    chk("alt.drop",  32'(drop_b), 32'(m_drop[1]));
    chk("alt.rd1",   rd1_b, exp_rd(1, Sr1));
    chk("alt.rd2",   rd2_b, exp_rd(1, Sr2));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    clr = 1'b0; write = 1'b0; wr_be = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Counts busy cycles of both instances over a bounded window.
  task automatic count_busy(input string name, input int exp_a, input int exp_b);
    int ca = 0;
    int cb = 0;
    for (int i = 0; i < 48; i++) begin
      sample();
      if (busy_a) ca++;
      if (busy_b) cb++;
      advance();
    end
    chk({name, ".busy_cycles_main"}, 32'(ca), 32'(exp_a));
    chk({name, ".busy_cycles_alt"},  32'(cb), 32'(exp_b));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        clr;
    logic        write;
    logic [3:0]  be;
    logic [4:0]  dr;
    logic [31:0] data;
    logic [4:0]  sr1;
    logic [4:0]  sr2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_alt_rd2;
    logic        e_drop;
    logic        e_busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'hF, 5'd5, 32'hAABBCCDD, 5'd5, 5'd0, 32'hAABBCCDD, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'h5, 5'd5, 32'h11223344, 5'd5, 5'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 5'd0, 32'h0,        5'd5, 5'd7, 32'hAA22CC44, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'hF, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'hF, 5'd3, 32'h12345678, 5'd3, 5'd0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'hF, 5'd3, 32'h00000001, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0};

    #2;
    do_reset();

    // Reset release: full clear on both instances, then every entry reads zero.
    count_busy("t1", 32, 8);
    for (int i = 0; i < 32; i++) begin
      Sr1 = 5'(i);
      Sr2 = 5'(31 - i);
      tick();
    end

    // Byte lanes, bypass, zero register and clr/write collision.
    for (int i = 0; i < 8; i++) begin
      clr = tbl[i].clr; write = tbl[i].write; wr_be = tbl[i].be; dr = tbl[i].dr;
      wrData = tbl[i].data; Sr1 = tbl[i].sr1; Sr2 = tbl[i].sr2;
      sample();
      chk($sformatf("tbl%0d.rd1", i),     rd1_a,          tbl[i].e_rd1);
      chk($sformatf("tbl%0d.rd2", i),     rd2_a,          tbl[i].e_rd2);
      chk($sformatf("tbl%0d.alt_rd2", i), rd2_b,          tbl[i].e_alt_rd2);
      chk($sformatf("tbl%0d.drop", i),    32'(drop_a),    32'(tbl[i].e_drop));
      chk($sformatf("tbl%0d.busy", i),    32'(busy_a),    32'(tbl[i].e_busy));
      advance();
    end

    // Collision aftermath: drop pulse, full clear, entry 3 wiped.
    idle();
    Sr1 = 5'd3;
    sample();
    chk("t5.drop_main", 32'(drop_a), 32'd1);
    chk("t5.drop_alt",  32'(drop_b), 32'd1);
    advance();
    count_busy("t5", 31, 7);
    sample();
    chk("t5.entry3", rd1_a, 32'h0);
    advance();

    // Write during a clear is dropped and leaves the entry at zero.
    clr = 1'b1;
    tick();
    clr = 1'b0; write = 1'b1; wr_be = 4'hF; dr = 5'd9; wrData = 32'd5; Sr1 = 5'd9;
    tick();
    idle();
    sample();
    chk("t6.drop_main", 32'(drop_a), 32'd1);
    advance();
    count_busy("t6", 30, 6);
    sample();
    chk("t6.entry9", rd1_a, 32'h0);
    advance();
    sample();
    chk("t6.drop_clears", 32'(drop_a), 32'd0);
    advance();

    // clr while already clearing restarts the sweep.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_busy("restart", 32, 8);

    // Reset in the middle of a clear reruns the full clear.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (2) tick();
    do_reset();
    count_busy("midreset", 32, 8);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      clr    = ($urandom_range(0, 39) == 0);
      write  = 1'($urandom_range(0, 1));
      wr_be  = 4'($urandom_range(0, 15));
      dr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wrData = $urandom;
      Sr1    = ($urandom_range(0, 2) == 0) ? dr : 5'($urandom_range(0, 31));
      Sr2    = ($urandom_range(0, 2) == 0) ? dr : 5'($urandom_range(0, 31));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
